pipeline_stall_ctrl: RTL and testbench
======================================

Name: pipeline_stall_ctrl

Overview:
Central advance/stall/flush controller for the LC-3b pipeline. It generates per-stage load and bubble (reset) enables from the instruction and data memory responses, the load-use hazard and branch redirect. It sequences multi-phase data accesses (indirect LDI/STI and TRAP vector fetch) through an explicit FSM. The stage count, flush depth, bubble position and access phase count are parametrised, so deeper pipelines reuse the block unchanged.

Parameters:
NUM_STAGES, 5, number of pipeline register banks; bit 0 = PC, bit i = register after stage i
FLUSH_DEPTH, 3, redirect squashes banks 1..FLUSH_DEPTH; must be < NUM_STAGES
LU_STAGE, 2, bank that receives the bubble on a load-use stall; 1 <= LU_STAGE <= FLUSH_DEPTH
MAX_PHASES, 2, maximum data-memory accesses per instruction; must be >= 1

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
inst_mem_resp  in  1  instruction fetch complete this cycle
data_mem_resp  in  1  current data access complete this cycle
mem_req_valid  in  1  instruction in MEM stage needs data memory
mem_phases  in  $clog2(MAX_PHASES+1)  accesses needed, 1..MAX_PHASES; sampled on entry to ACCESS
load_use  in  1  ID consumer depends on a load in EX
redirect  in  1  taken branch/jump/trap resolved in MEM
stage_load  out  NUM_STAGES  per-bank load enable
stage_reset  out  NUM_STAGES  per-bank bubble insert
mem_access_en  out  1  gates data_mem_read/write; low once the instruction's accesses are done
mem_phase  out  $clog2(MAX_PHASES)  current access index; selects the address mux
phase_addr_load  out  1  load the indirect-address register from rdata
perf_stall_cnt  out  32  performance counter (see Optional Feature)
perf_flush_cnt  out  32  performance counter (see Optional Feature)

Behaviour:
- FSM states: IDLE, ACCESS, DONE. Reset puts the FSM in IDLE with mem_phase=0.
- During reset: stage_load=0, stage_reset=all 1s, mem_access_en=0, phase_addr_load=0.
- data_ok = ~mem_req_valid | (state==DONE) | (state==ACCESS & data_mem_resp & mem_phase==mem_phases-1).
- advance = inst_mem_resp & data_ok. This is combinational and has zero-cycle latency.
- IDLE -> ACCESS when mem_req_valid. mem_access_en=1 in IDLE (with mem_req_valid) and in ACCESS.
- In ACCESS, data_mem_resp with mem_phase < mem_phases-1: increment mem_phase, pulse phase_addr_load for one cycle, stay in ACCESS.
- In ACCESS, data_mem_resp on the last phase:
  - with advance: mem_phase=0, go to IDLE (re-enter ACCESS next cycle if the new MEM instruction has mem_req_valid).
  - without advance: go to DONE.
- In DONE, mem_access_en=0 so no duplicate access is issued. DONE -> IDLE with mem_phase=0 on advance.
- No advance: stage_load=0 and stage_reset=0 everywhere. The pipeline freezes and the CC/regfile writeback is unaffected.
- Advance with redirect: stage_load all 1. stage_reset bits 1..FLUSH_DEPTH = 1. load_use is ignored.
- Advance with load_use, no redirect:
  - stage_load bits 0..LU_STAGE-1 = 0.
  - bank LU_STAGE has load=1 and reset=1 (bubble).
  - all higher banks load.
- Advance, neither hazard: stage_load all 1, stage_reset all 0.
- mem_req_valid falling in ACCESS does not occur; if it does, the FSM still completes the sequence.

Optional Feature:
Macro STALL_CNT_EN.
- Defined: perf_stall_cnt increments on every non-reset cycle with advance=0. perf_flush_cnt increments on each advance with redirect. Both saturate at 32'hFFFFFFFF and clear on reset.
- Undefined: both outputs are constant 0 and no counter flops exist.

Decomposition:
- lc3b_types gains the ctrl_state_t enum (IDLE/ACCESS/DONE) and the bank index constants BANK_PC=0, BANK_FD=1, BANK_DX=2, BANK_XM=3, BANK_MW=4.
- One sub-module, mem_phase_fsm, owns state, mem_phase, phase_addr_load, mem_access_en and data_ok. The mask generation and counters live in the top.

Test Plan:
- Direct load: mem_req_valid=1, mem_phases=1, data_mem_resp at cycle 3, inst_mem_resp=1 -> advance only at cycle 3; stage_load=5'b11111; FSM returns to IDLE.
- Indirect: mem_phases=2, data_mem_resp at cycles 2 and 5 -> phase_addr_load at cycle 2; mem_phase 0->1; advance at cycle 5; mem_phase back to 0.
- Data completes before fetch: data_mem_resp at cycle 2, inst_mem_resp at cycle 6 -> DONE at cycles 3-5 with mem_access_en=0; single advance at cycle 6.
- Load-use: load_use=1 with advance -> stage_load=5'b11100, stage_reset=5'b00100.
- Redirect with load_use simultaneously -> stage_load=5'b11111, stage_reset=5'b01110; perf_flush_cnt +1 under STALL_CNT_EN.
- Reset asserted mid-ACCESS at mem_phase=1 -> next cycle IDLE, mem_phase=0, counters 0; reset cycle drives stage_reset=5'b11111.

Source files
------------

// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared LC-3b pipeline types: memory-phase FSM states, bank indices
// and a saturating increment for the performance counters.
package lc3b_types;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } ctrl_state_t;

  localparam int BANK_PC = 0;
  localparam int BANK_FD = 1;
  localparam int BANK_DX = 2;
  localparam int BANK_XM = 3;
  localparam int BANK_MW = 4;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_mem_phase_fsm.sv
// Multi-phase data access sequencer (IDLE/ACCESS/DONE).
// In: clk, reset, inst/data resp, mem_req_valid, mem_phases.
// Out: data_ok, mem_access_en, mem_phase, phase_addr_load.
module mem_phase_fsm
  import lc3b_types::*;
#(
  parameter int MAX_PHASES = 2,
  parameter int CW = $clog2(MAX_PHASES + 1),
  parameter int PW = (MAX_PHASES > 1) ? $clog2(MAX_PHASES) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inst_mem_resp,
  input  logic          data_mem_resp,
  input  logic          mem_req_valid,
  input  logic [CW-1:0] mem_phases,
  output logic          data_ok,
  output logic          mem_access_en,
  output logic [PW-1:0] mem_phase,
  output logic          phase_addr_load
);

  ctrl_state_t   state;
  logic [CW-1:0] phases_q;
  logic [CW-1:0] last;
  logic          is_last;
  logic          resp_last;
  logic          adv;

  // A zero phase count is treated as a single access.
  assign last      = (phases_q == '0) ? '0 : phases_q - CW'(1);
  assign is_last   = CW'(mem_phase) >= last;
  assign resp_last = (state == ACCESS) & data_mem_resp & is_last;

  assign data_ok = ~mem_req_valid | (state == DONE) | resp_last;
  assign adv     = inst_mem_resp & data_ok;

  assign mem_access_en = ~reset &
    (((state == IDLE) & mem_req_valid) | (state == ACCESS));

  assign phase_addr_load = ~reset & (state == ACCESS) &
    data_mem_resp & ~is_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      mem_phase <= '0;
      phases_q  <= CW'(1);
    end else begin
      unique case (state)
        IDLE: begin
          if (mem_req_valid) begin
            state     <= ACCESS;
            phases_q  <= mem_phases;
            mem_phase <= '0;
          end
        end
        ACCESS: begin
          if (data_mem_resp) begin
            if (!is_last) begin
              mem_phase <= mem_phase + PW'(1);
            end else if (adv) begin
              state     <= IDLE;
              mem_phase <= '0;
            end else begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          if (adv) begin
            state     <= IDLE;
            mem_phase <= '0;
          end
        end
        default: begin
          state     <= IDLE;
          mem_phase <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline advance/stall/flush controller; per-bank load/bubble masks.
// Optional perf counters enabled by macro STALL_CNT_EN.
module pipeline_stall_ctrl
  import lc3b_types::*;
#(
  parameter int NUM_STAGES  = 5,
  parameter int FLUSH_DEPTH = 3,
  parameter int LU_STAGE    = 2,
  parameter int MAX_PHASES  = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic inst_mem_resp,
  input  logic data_mem_resp,
  input  logic mem_req_valid,
  input  logic [$clog2(MAX_PHASES+1)-1:0] mem_phases,
  input  logic load_use,
  input  logic redirect,
  output logic [NUM_STAGES-1:0] stage_load,
  output logic [NUM_STAGES-1:0] stage_reset,
  output logic mem_access_en,
  output logic [((MAX_PHASES>1)?$clog2(MAX_PHASES):1)-1:0] mem_phase,
  output logic phase_addr_load,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
);

  localparam int CW = $clog2(MAX_PHASES + 1);
  localparam int PW = (MAX_PHASES > 1) ? $clog2(MAX_PHASES) : 1;

  localparam logic [NUM_STAGES-1:0] ONES = '1;
  localparam logic [NUM_STAGES-1:0] FLUSH_MASK =
    (ONES >> (NUM_STAGES - FLUSH_DEPTH)) << 1;
  localparam logic [NUM_STAGES-1:0] LU_LOAD = ONES << LU_STAGE;
  localparam logic [NUM_STAGES-1:0] LU_BUB =
    NUM_STAGES'(1) << LU_STAGE;

  logic data_ok;
  logic advance;

  mem_phase_fsm #(
    .MAX_PHASES(MAX_PHASES),
    .CW        (CW),
    .PW        (PW)
  ) u_fsm (
    .clk            (clk),
    .reset          (reset),
    .inst_mem_resp  (inst_mem_resp),
    .data_mem_resp  (data_mem_resp),
    .mem_req_valid  (mem_req_valid),
    .mem_phases     (mem_phases),
    .data_ok        (data_ok),
    .mem_access_en  (mem_access_en),
    .mem_phase      (mem_phase),
    .phase_addr_load(phase_addr_load)
  );

  assign advance = inst_mem_resp & data_ok;

  // Redirect wins over load_use: the stalled consumer is squashed anyway.
  always_comb begin
    stage_load  = '0;
    stage_reset = '0;
    if (reset) begin
      stage_reset = ONES;
    end else if (advance) begin
      if (redirect) begin
        stage_load  = ONES;
        stage_reset = FLUSH_MASK;
      end else if (load_use) begin
        stage_load  = LU_LOAD;
        stage_reset = LU_BUB;
      end else begin
        stage_load = ONES;
      end
    end
  end

`ifdef STALL_CNT_EN
  logic [31:0] stall_q;
  logic [31:0] flush_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!advance)
        stall_q <= sat_inc(stall_q);
      if (advance && redirect)
        flush_q <= sat_inc(flush_q);
    end
  end

  assign perf_stall_cnt = stall_q;
  assign perf_flush_cnt = flush_q;
`else
  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl: mask table plus
// multi-cycle FSM sequences, counters checked against a local model.
module tb_pipeline_stall_ctrl;

`ifdef STALL_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       inst_mem_resp;
  logic       data_mem_resp;
  logic       mem_req_valid;
  logic [1:0] mem_phases;
  logic       load_use;
  logic       redirect;
  logic [4:0] stage_load;
  logic [4:0] stage_reset;
  logic       mem_access_en;
  logic [0:0] mem_phase;
  logic       phase_addr_load;
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int m_stall = 0;
  int m_flush = 0;

  always #5 clk = ~clk;

  pipeline_stall_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .inst_mem_resp  (inst_mem_resp),
    .data_mem_resp  (data_mem_resp),
    .mem_req_valid  (mem_req_valid),
    .mem_phases     (mem_phases),
    .load_use       (load_use),
    .redirect       (redirect),
    .stage_load     (stage_load),
    .stage_reset    (stage_reset),
    .mem_access_en  (mem_access_en),
    .mem_phase      (mem_phase),
    .phase_addr_load(phase_addr_load),
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
  );

  typedef struct {
    logic       inst;
    logic       lu;
    logic       rd;
    logic [4:0] el;
    logic [4:0] er;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic i, input logic d, input logic q,
                       input logic [1:0] np, input logic lu,
                       input logic rd, input logic rs);
    @(negedge clk);
    inst_mem_resp = i;
    data_mem_resp = d;
    mem_req_valid = q;
    mem_phases    = np;
    load_use      = lu;
    redirect      = rd;
    reset         = rs;
  endtask

  task automatic cyc(input string nm, input logic [4:0] el,
                     input logic [4:0] er, input logic aen,
                     input logic [0:0] ph, input logic pal);
    #1;
    chk({nm, " load"}, 32'(stage_load), 32'(el));
    chk({nm, " rst"}, 32'(stage_reset), 32'(er));
    chk({nm, " aen"}, 32'(mem_access_en), 32'(aen));
    chk({nm, " phase"}, 32'(mem_phase), 32'(ph));
    chk({nm, " pal"}, 32'(phase_addr_load), 32'(pal));
    if (!reset) begin
      chk({nm, " stallcnt"}, perf_stall_cnt,
          CNT_EN ? 32'(m_stall) : 32'd0);
      chk({nm, " flushcnt"}, perf_flush_cnt,
          CNT_EN ? 32'(m_flush) : 32'd0);
    end
    if (reset) begin
      m_stall = 0;
      m_flush = 0;
    end else if (el == 5'b0) begin
      m_stall++;
    end else if (redirect) begin
      m_flush++;
    end
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b0, 5'b11111, 5'b00000};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 5'b00000, 5'b00000};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 5'b11100, 5'b00100};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 5'b11111, 5'b01110};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 5'b11111, 5'b01110};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 5'b00000, 5'b00000};

    reset = 1'b1;
    inst_mem_resp = 1'b0;
    data_mem_resp = 1'b0;
    mem_req_valid = 1'b0;
    mem_phases = 2'd1;
    load_use = 1'b0;
    redirect = 1'b0;
    repeat (2) @(posedge clk);

    drive(1, 1, 1, 2'd1, 0, 0, 1);
    cyc("reset", 5'b00000, 5'b11111, 0, 0, 0);

    for (int k = 0; k < 6; k++) begin
      drive(vecs[k].inst, 0, 0, 2'd1, vecs[k].lu, vecs[k].rd, 0);
      cyc($sformatf("vec%0d", k), vecs[k].el, vecs[k].er, 0, 0, 0);
    end

    drive(1, 0, 1, 2'd1, 0, 0, 0);
    cyc("dir c0", 5'b00000, 5'b00000, 1, 0, 0);
    drive(1, 0, 1, 2'd1, 0, 0, 0);
    cyc("dir c1", 5'b00000, 5'b00000, 1, 0, 0);
    drive(1, 0, 1, 2'd1, 0, 0, 0);
    cyc("dir c2", 5'b00000, 5'b00000, 1, 0, 0);
    drive(1, 1, 1, 2'd1, 0, 0, 0);
    cyc("dir c3", 5'b11111, 5'b00000, 1, 0, 0);
    drive(1, 0, 0, 2'd1, 0, 0, 0);
    cyc("dir c4", 5'b11111, 5'b00000, 0, 0, 0);

    drive(1, 0, 1, 2'd2, 0, 0, 0);
    cyc("ind c0", 5'b00000, 5'b00000, 1, 0, 0);
    drive(1, 0, 1, 2'd2, 0, 0, 0);
    cyc("ind c1", 5'b00000, 5'b00000, 1, 0, 0);
    drive(1, 1, 1, 2'd2, 0, 0, 0);
    cyc("ind c2", 5'b00000, 5'b00000, 1, 0, 1);
    drive(1, 0, 1, 2'd2, 0, 0, 0);
    cyc("ind c3", 5'b00000, 5'b00000, 1, 1, 0);
    drive(1, 0, 1, 2'd2, 0, 0, 0);
    cyc("ind c4", 5'b00000, 5'b00000, 1, 1, 0);
    drive(1, 1, 1, 2'd2, 0, 0, 0);
    cyc("ind c5", 5'b11111, 5'b00000, 1, 1, 0);
    drive(1, 0, 0, 2'd2, 0, 0, 0);
    cyc("ind c6", 5'b11111, 5'b00000, 0, 0, 0);

    drive(0, 0, 1, 2'd1, 0, 0, 0);
    cyc("done c0", 5'b00000, 5'b00000, 1, 0, 0);
    drive(0, 0, 1, 2'd1, 0, 0, 0);
    cyc("done c1", 5'b00000, 5'b00000, 1, 0, 0);
    drive(0, 1, 1, 2'd1, 0, 0, 0);
    cyc("done c2", 5'b00000, 5'b00000, 1, 0, 0);
    for (int c = 3; c < 6; c++) begin
      drive(0, 0, 1, 2'd1, 0, 0, 0);
      cyc($sformatf("done c%0d", c), 5'b00000, 5'b00000, 0, 0, 0);
    end
    drive(1, 0, 1, 2'd1, 1, 0, 0);
    cyc("done c6", 5'b11100, 5'b00100, 0, 0, 0);
    drive(1, 0, 0, 2'd1, 0, 0, 0);
    cyc("done c7", 5'b11111, 5'b00000, 0, 0, 0);

    drive(1, 0, 1, 2'd2, 0, 0, 0);
    cyc("rst c0", 5'b00000, 5'b00000, 1, 0, 0);
    drive(1, 0, 1, 2'd2, 0, 0, 0);
    cyc("rst c1", 5'b00000, 5'b00000, 1, 0, 0);
    drive(1, 1, 1, 2'd2, 0, 0, 0);
    cyc("rst c2", 5'b00000, 5'b00000, 1, 0, 1);
    drive(1, 1, 1, 2'd2, 0, 1, 1);
    cyc("rst c3", 5'b00000, 5'b11111, 0, 1, 0);
    drive(1, 0, 0, 2'd2, 0, 0, 0);
    cyc("rst c4", 5'b11111, 5'b00000, 0, 0, 0);
    drive(1, 0, 0, 2'd2, 0, 1, 0);
    cyc("rst c5", 5'b11111, 5'b01110, 0, 0, 0);
    drive(0, 0, 0, 2'd1, 0, 0, 0);
    cyc("rst c6", 5'b00000, 5'b00000, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
